// File: rtl/mc_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: state codes,
// opcode/funct constants, datapath select encodings and instruction classes.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_JR    = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [1:0] NPC_PC4 = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_JAL = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [1:0] WA_RT  = 2'b00;
  localparam logic [1:0] WA_RD  = 2'b01;
  localparam logic [1:0] WA_R31 = 2'b10;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;

  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_SHL2 = 2'b10;
  localparam logic [1:0] EXT_LUI  = 2'b11;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;

  typedef enum logic [3:0] {
    CL_NONE    = 4'd0,
    CL_ADDU    = 4'd1,
    CL_SUBU    = 4'd2,
    CL_JR      = 4'd3,
    CL_ORI     = 4'd4,
    CL_LW      = 4'd5,
    CL_SW      = 4'd6,
    CL_BEQ     = 4'd7,
    CL_LUI     = 4'd8,
    CL_JAL     = 4'd9,
    CL_ILLEGAL = 4'd10
  } instr_class_e;

  // ALU-side selects for a class, packed as {alub_op, ext_op, alu_op}.
  function automatic logic [4:0] alu_sel(instr_class_e cls);
    logic       alub;
    logic [1:0] ext;
    logic [1:0] alu;
    alub = 1'b0;
    ext  = EXT_ZERO;
    alu  = ALU_ADD;
    case (cls)
      CL_ADDU: alub = 1'b1;
      CL_SUBU: begin alub = 1'b1; alu = ALU_SUB; end
      CL_ORI:  alu = ALU_OR;
      CL_LUI:  begin ext = EXT_LUI; alu = ALU_OR; end
      CL_LW, CL_SW: ext = EXT_SIGN;
      CL_BEQ:  begin alub = 1'b1; alu = ALU_SUB; ext = EXT_SHL2; end
      default: ;
    endcase
    return {alub, ext, alu};
  endfunction

endpackage

// File: rtl/mc_control_instr_class_dec.sv
// Combinational opcode/funct to instruction-class decoder; anything not in
// the supported set maps to the illegal class.
module instr_class_dec
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] instr_op,
  input  logic [5:0] instr_func,
  output logic [3:0] cls
);

  instr_class_e cls_e;

  always_comb begin
    cls_e = CL_ILLEGAL;
    case (instr_op)
      OP_RTYPE: begin
        case (instr_func)
          FN_ADDU: cls_e = CL_ADDU;
          FN_SUBU: cls_e = CL_SUBU;
          FN_JR:   cls_e = CL_JR;
          default: cls_e = CL_ILLEGAL;
        endcase
      end
      OP_ORI:  cls_e = CL_ORI;
      OP_LW:   cls_e = CL_LW;
      OP_SW:   cls_e = CL_SW;
      OP_BEQ:  cls_e = CL_BEQ;
      OP_LUI:  cls_e = CL_LUI;
      OP_JAL:  cls_e = CL_JAL;
      default: cls_e = CL_ILLEGAL;
    endcase
  end

  assign cls = cls_e;

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing,
// datapath select strobes and a retired-instruction counter.
module mc_control
  import mips_ctrl_pkg::*;
#(
  parameter int CNT_W        = 32,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       instr_op,
  input  logic [5:0]       instr_func,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             pc_we,
  output logic             ir_we,
  output logic [1:0]       npc_op,
  output logic [1:0]       wa_op,
  output logic [1:0]       wd_op,
  output logic             alub_op,
  output logic [1:0]       ext_op,
  output logic [1:0]       alu_op,
  output logic             dwe,
  output logic             dre,
  output logic             rwe,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  instr_class_e     cls_q, cls_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       dec_raw;
  instr_class_e     dec_cls;
  logic             retire;

  instr_class_dec u_dec (
    .instr_op   (instr_op),
    .instr_func (instr_func),
    .cls        (dec_raw)
  );

  assign dec_cls = instr_class_e'(dec_raw);

  // Memory handshake: mem_req stays high every cycle of FETCH/MEM until the
  // cycle mem_ready is seen high; the transfer completes on that rising edge.
  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    retire  = 1'b0;
    mem_req = 1'b0;
    pc_we   = 1'b0;
    ir_we   = 1'b0;
    npc_op  = NPC_PC4;
    wa_op   = WA_RT;
    wd_op   = WD_ALU;
    alub_op = 1'b0;
    ext_op  = EXT_ZERO;
    alu_op  = ALU_ADD;
    dwe     = 1'b0;
    dre     = 1'b0;
    rwe     = 1'b0;
    halted  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          CL_JAL: begin
            rwe     = 1'b1;
            wa_op   = WA_R31;
            wd_op   = WD_PC4;
            pc_we   = 1'b1;
            npc_op  = NPC_JAL;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CL_JR: begin
            pc_we   = 1'b1;
            npc_op  = NPC_JR;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end
          CL_ILLEGAL: begin
            if (ILLEGAL_TRAP != 0) begin
              state_d = ST_HALT;
            end else begin
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
          end
          default: state_d = ST_EXEC;
        endcase
      end
      ST_EXEC: begin
        {alub_op, ext_op, alu_op} = alu_sel(cls_q);
        if (cls_q == CL_BEQ) begin
          pc_we   = zero;
          npc_op  = NPC_BR;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (cls_q == CL_LW || cls_q == CL_SW) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WB;
        end
      end
      ST_MEM: begin
        {alub_op, ext_op, alu_op} = alu_sel(cls_q);
        mem_req = 1'b1;
        dre     = (cls_q == CL_LW);
        dwe     = (cls_q == CL_SW);
        if (mem_ready) begin
          if (cls_q == CL_SW) begin
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end
      end
      ST_WB: begin
        {alub_op, ext_op, alu_op} = alu_sel(cls_q);
        rwe     = 1'b1;
        wa_op   = (cls_q == CL_ADDU || cls_q == CL_SUBU) ? WA_RD : WA_RT;
        wd_op   = (cls_q == CL_LW) ? WD_MEM : WD_ALU;
        retire  = 1'b1;
        state_d = ST_FETCH;
      end
      ST_HALT: halted = 1'b1;
      default: state_d = ST_FETCH;
    endcase

    cnt_d = cnt_q + CNT_W'(retire);

    // Outputs are forced quiet for as long as reset is held.
    if (reset) begin
      mem_req = 1'b0;
      pc_we   = 1'b0;
      ir_we   = 1'b0;
      npc_op  = NPC_PC4;
      wa_op   = WA_RT;
      wd_op   = WD_ALU;
      alub_op = 1'b0;
      ext_op  = EXT_ZERO;
      alu_op  = ALU_ADD;
      dwe     = 1'b0;
      dre     = 1'b0;
      rwe     = 1'b0;
      halted  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      cls_q   <= CL_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cls_q   <= cls_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_cnt = cnt_q;
  assign state     = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control: three instances (trap, no-trap, 4-bit counter)
// share stimulus; each instruction is checked cycle by cycle against a model.
module tb_mc_control;

  localparam int I_ADDU = 0, I_SUBU = 1, I_JR = 2, I_ORI = 3, I_LW = 4;
  localparam int I_SW = 5, I_BEQ = 6, I_LUI = 7, I_JAL = 8, I_ILL = 9;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] instr_op, instr_func;
  logic       zero, mem_ready;

  logic a_mem_req, a_pc_we, a_ir_we, a_alub_op, a_dwe, a_dre, a_rwe, a_halted;
  logic [1:0] a_npc_op, a_wa_op, a_wd_op, a_ext_op, a_alu_op;
  logic [31:0] a_instr_cnt;
  logic [2:0] a_state;

  logic n_mem_req, n_pc_we, n_ir_we, n_alub_op, n_dwe, n_dre, n_rwe, n_halted;
  logic [1:0] n_npc_op, n_wa_op, n_wd_op, n_ext_op, n_alu_op;
  logic [31:0] n_instr_cnt;
  logic [2:0] n_state;

  logic w_mem_req, w_pc_we, w_ir_we, w_alub_op, w_dwe, w_dre, w_rwe, w_halted;
  logic [1:0] w_npc_op, w_wa_op, w_wd_op, w_ext_op, w_alu_op;
  logic [3:0] w_instr_cnt;
  logic [2:0] w_state;

  logic [17:0] a_vec, n_vec, w_vec;
  assign a_vec = {a_mem_req, a_pc_we, a_ir_we, a_npc_op, a_wa_op, a_wd_op,
                  a_alub_op, a_ext_op, a_alu_op, a_dwe, a_dre, a_rwe, a_halted};
  assign n_vec = {n_mem_req, n_pc_we, n_ir_we, n_npc_op, n_wa_op, n_wd_op,
                  n_alub_op, n_ext_op, n_alu_op, n_dwe, n_dre, n_rwe, n_halted};
  assign w_vec = {w_mem_req, w_pc_we, w_ir_we, w_npc_op, w_wa_op, w_wd_op,
                  w_alub_op, w_ext_op, w_alu_op, w_dwe, w_dre, w_rwe, w_halted};

  mc_control #(.CNT_W(32), .ILLEGAL_TRAP(1)) dut (
    .clk(clk), .reset(reset), .instr_op(instr_op), .instr_func(instr_func),
    .zero(zero), .mem_ready(mem_ready), .mem_req(a_mem_req), .pc_we(a_pc_we),
    .ir_we(a_ir_we), .npc_op(a_npc_op), .wa_op(a_wa_op), .wd_op(a_wd_op),
    .alub_op(a_alub_op), .ext_op(a_ext_op), .alu_op(a_alu_op), .dwe(a_dwe),
    .dre(a_dre), .rwe(a_rwe), .halted(a_halted), .instr_cnt(a_instr_cnt),
    .state(a_state));

  mc_control #(.CNT_W(32), .ILLEGAL_TRAP(0)) dut_nop (
    .clk(clk), .reset(reset), .instr_op(instr_op), .instr_func(instr_func),
    .zero(zero), .mem_ready(mem_ready), .mem_req(n_mem_req), .pc_we(n_pc_we),
    .ir_we(n_ir_we), .npc_op(n_npc_op), .wa_op(n_wa_op), .wd_op(n_wd_op),
    .alub_op(n_alub_op), .ext_op(n_ext_op), .alu_op(n_alu_op), .dwe(n_dwe),
    .dre(n_dre), .rwe(n_rwe), .halted(n_halted), .instr_cnt(n_instr_cnt),
    .state(n_state));

  mc_control #(.CNT_W(4), .ILLEGAL_TRAP(1)) dut_w4 (
    .clk(clk), .reset(reset), .instr_op(instr_op), .instr_func(instr_func),
    .zero(zero), .mem_ready(mem_ready), .mem_req(w_mem_req), .pc_we(w_pc_we),
    .ir_we(w_ir_we), .npc_op(w_npc_op), .wa_op(w_wa_op), .wd_op(w_wd_op),
    .alub_op(w_alub_op), .ext_op(w_ext_op), .alu_op(w_alu_op), .dwe(w_dwe),
    .dre(w_dre), .rwe(w_rwe), .halted(w_halted), .instr_cnt(w_instr_cnt),
    .state(w_state));

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_cnt, exp_cnt_n;
  logic [3:0]  exp_cnt_w;

  function automatic logic [11:0] enc(int ins);
    case (ins)
      I_ADDU:  return 12'b000000_100001;
      I_SUBU:  return 12'b000000_100011;
      I_JR:    return 12'b000000_001000;
      I_ORI:   return {6'b001101, 6'($urandom)};
      I_LW:    return {6'b100011, 6'($urandom)};
      I_SW:    return {6'b101011, 6'($urandom)};
      I_BEQ:   return {6'b000100, 6'($urandom)};
      I_LUI:   return {6'b001111, 6'($urandom)};
      I_JAL:   return {6'b000011, 6'($urandom)};
      default: return {6'b111111, 6'($urandom)};
    endcase
  endfunction

  // Cycles per instruction with zero-wait memory.
  function automatic int base_cycles(int ins);
    case (ins)
      I_JAL, I_JR: return 2;
      I_BEQ:       return 3;
      I_LW:        return 5;
      default:     return 4;
    endcase
  endfunction

  // Expected strobe vector for one cycle spent in phase ph (0=F..5=H).
  function automatic logic [17:0] exp_out(int ph, int ins, logic z, logic rdy);
    logic mr, pw, iw, dw, dr, rw, h, alub;
    logic [1:0] npc, wa, wd, ext, alu;
    mr = 0; pw = 0; iw = 0; dw = 0; dr = 0; rw = 0; h = 0; alub = 0;
    npc = 0; wa = 0; wd = 0; ext = 0; alu = 0;
    if (ph == 2 || ph == 3 || ph == 4) begin
      case (ins)
        I_ADDU: alub = 1;
        I_SUBU: begin alub = 1; alu = 2'b01; end
        I_ORI:  alu = 2'b10;
        I_LUI:  begin ext = 2'b11; alu = 2'b10; end
        I_LW, I_SW: ext = 2'b01;
        I_BEQ:  begin alub = 1; alu = 2'b01; ext = 2'b10; end
        default: ;
      endcase
    end
    case (ph)
      0: begin mr = 1; if (rdy) begin iw = 1; pw = 1; end end
      1: begin
        if (ins == I_JAL) begin rw = 1; wa = 2'b10; wd = 2'b10; pw = 1; npc = 2'b10; end
        else if (ins == I_JR) begin pw = 1; npc = 2'b11; end
      end
      2: if (ins == I_BEQ) begin pw = z; npc = 2'b01; end
      3: begin mr = 1; dr = (ins == I_LW); dw = (ins == I_SW); end
      4: begin
        rw = 1;
        wa = (ins == I_ADDU || ins == I_SUBU) ? 2'b01 : 2'b00;
        wd = (ins == I_LW) ? 2'b01 : 2'b00;
      end
      5: h = 1;
      default: ;
    endcase
    return {mr, pw, iw, npc, wa, wd, alub, ext, alu, dw, dr, rw, h};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    {instr_op, instr_func} = 12'($urandom);
    zero = 1'($urandom);
    mem_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (a_vec !== 18'd0 || a_state !== 3'd0 || a_instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: vec=%h state=%0d cnt=%0d, required 0/0/0", a_vec, a_state, a_instr_cnt);
    end
    n_checks++;
    if (w_instr_cnt !== 4'd0 || n_instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_counts: w=%0d n=%0d, required 0", w_instr_cnt, n_instr_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0; exp_cnt_n = 0; exp_cnt_w = 0;
  endtask

  // Runs one instruction through the main instance; entered and left #1 after a rising edge.
  task automatic run_instr(input int ins, input logic z, input int fw, input int mw,
                           input string name, output int ncyc);
    int   ph_q[$];
    logic rdy_q[$];
    for (int i = 0; i < fw; i++) begin ph_q.push_back(0); rdy_q.push_back(0); end
    ph_q.push_back(0); rdy_q.push_back(1);
    ph_q.push_back(1); rdy_q.push_back(0);
    if (ins != I_JAL && ins != I_JR && ins != I_ILL) begin
      ph_q.push_back(2); rdy_q.push_back(0);
      if (ins == I_LW || ins == I_SW) begin
        for (int i = 0; i < mw; i++) begin ph_q.push_back(3); rdy_q.push_back(0); end
        ph_q.push_back(3); rdy_q.push_back(1);
      end
      if (ins != I_BEQ && ins != I_SW) begin ph_q.push_back(4); rdy_q.push_back(0); end
    end
    ncyc = 0;
    foreach (ph_q[k]) begin
      {instr_op, instr_func} = (ph_q[k] == 1) ? enc(ins) : 12'($urandom);
      zero      = (ph_q[k] == 2) ? z : 1'($urandom);
      mem_ready = (ph_q[k] == 0 || ph_q[k] == 3) ? rdy_q[k] : 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (a_state !== 3'(ph_q[k])) begin
        n_fail++;
        $display("FAIL %s state c%0d: got %0d, required %0d", name, k, a_state, ph_q[k]);
      end
      n_checks++;
      if (a_vec !== exp_out(ph_q[k], ins, zero, mem_ready)) begin
        n_fail++;
        $display("FAIL %s strobes c%0d: got %h, required %h", name, k, a_vec,
                 exp_out(ph_q[k], ins, zero, mem_ready));
      end
      ncyc++;
      @(posedge clk); #1;
    end
    if (ins != I_ILL) begin exp_cnt++; exp_cnt_w++; end
    exp_cnt_n++;
    n_checks++;
    if (a_state !== ((ins == I_ILL) ? 3'd5 : 3'd0) || a_instr_cnt !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s end: state=%0d cnt=%0d, required cnt %0d", name, a_state, a_instr_cnt, exp_cnt);
    end
    n_checks++;
    if (n_instr_cnt !== exp_cnt_n || w_instr_cnt !== exp_cnt_w) begin
      n_fail++;
      $display("FAIL %s side_counts: n=%0d w=%0d, required %0d %0d", name,
               n_instr_cnt, w_instr_cnt, exp_cnt_n, exp_cnt_w);
    end
  endtask

  task automatic check_cycles(input string name, input int got, input int req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s cycles: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    do_reset();
  endtask

  task automatic test_addu();
    int c;
    do_reset();
    run_instr(I_ADDU, 1'b0, 0, 0, "addu", c);
    check_cycles("addu", c, 4);
  endtask

  task automatic test_lw_wait();
    int c;
    do_reset();
    run_instr(I_LW, 1'b0, 0, 3, "lw_wait", c);
    check_cycles("lw_wait", c, 8);
  endtask

  task automatic test_beq();
    int c;
    do_reset();
    run_instr(I_BEQ, 1'b1, 0, 0, "beq_taken", c);
    check_cycles("beq_taken", c, 3);
    run_instr(I_BEQ, 1'b0, 0, 0, "beq_not", c);
    check_cycles("beq_not", c, 3);
    n_checks++;
    if (a_instr_cnt !== 32'd2) begin
      n_fail++;
      $display("FAIL beq_count: got %0d, required 2", a_instr_cnt);
    end
  endtask

  task automatic test_jal();
    int c;
    do_reset();
    run_instr(I_JAL, 1'b0, 1, 0, "jal", c);
    check_cycles("jal", c, 3);
  endtask

  task automatic test_illegal();
    int c;
    do_reset();
    run_instr(I_ILL, 1'b0, 0, 0, "illegal", c);
    n_checks++;
    if (n_state !== 3'd0 || n_halted !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_nop: state=%0d halted=%0d, required 0/0", n_state, n_halted);
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = 1'b1;
      {instr_op, instr_func} = 12'($urandom);
      zero = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (a_state !== 3'd5 || a_vec !== 18'd1 || a_instr_cnt !== 32'd0) begin
        n_fail++;
        $display("FAIL halt_hold: state=%0d vec=%h cnt=%0d, required 5/00001/0", a_state, a_vec, a_instr_cnt);
      end
      @(posedge clk); #1;
    end
    do_reset();
    n_checks++;
    if (a_state !== 3'd0 || a_instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL halt_exit: state=%0d cnt=%0d, required 0/0", a_state, a_instr_cnt);
    end
  endtask

  task automatic test_wrap();
    int c;
    do_reset();
    for (int i = 0; i < 16; i++) run_instr(I_JR, 1'b0, 0, 0, "jr_wrap", c);
    n_checks++;
    if (w_instr_cnt !== 4'd0 || a_instr_cnt !== 32'd16) begin
      n_fail++;
      $display("FAIL wrap: w=%0d a=%0d, required 0/16", w_instr_cnt, a_instr_cnt);
    end
  endtask

  task automatic test_reset_in_mem();
    int c;
    do_reset();
    run_instr(I_ADDU, 1'b0, 0, 0, "pre_sw", c);
    mem_ready = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    {instr_op, instr_func} = enc(I_SW);
    @(negedge clk); @(posedge clk); #1;
    @(negedge clk); @(posedge clk); #1;
    mem_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (a_state !== 3'd3 || a_dwe !== 1'b1 || a_instr_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL sw_mem: state=%0d dwe=%0d cnt=%0d, required 3/1/1", a_state, a_dwe, a_instr_cnt);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (a_dwe !== 1'b0 || a_mem_req !== 1'b0 || a_state !== 3'd0 || a_instr_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL sw_abort: dwe=%0d req=%0d state=%0d cnt=%0d, required 0", a_dwe, a_mem_req, a_state, a_instr_cnt);
    end
    mem_ready = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    exp_cnt = 0; exp_cnt_n = 0; exp_cnt_w = 0;
    @(negedge clk);
    n_checks++;
    if (a_state !== 3'd0 || a_instr_cnt !== 32'd0 || a_mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL post_abort: state=%0d cnt=%0d req=%0d, required 0/0/1", a_state, a_instr_cnt, a_mem_req);
    end
    @(posedge clk); #1;
    do_reset();
  endtask

  task automatic test_random();
    int c, ins, fw, mw;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      ins = $urandom_range(0, 8);
      fw  = $urandom_range(0, 2);
      mw  = $urandom_range(0, 2);
      run_instr(ins, 1'($urandom_range(0, 1)), fw, mw, "random", c);
      check_cycles("random", c, base_cycles(ins) + fw + ((ins == I_LW || ins == I_SW) ? mw : 0));
    end
  endtask

  initial begin
    reset = 1'b1;
    instr_op = 0; instr_func = 0; zero = 0; mem_ready = 0;
    exp_cnt = 0; exp_cnt_n = 0; exp_cnt_w = 0;
    test_reset();
    test_addu();
    test_lw_wait();
    test_beq();
    test_jal();
    test_illegal();
    test_wrap();
    test_reset_in_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
